pc_sequencer: RTL and testbench

//  Parametrised fetch-address sequencer for the pipelined ARMv8 core: holds the fetch PC, steps it by one instruction per cycle,
//  and redirects it when a resolved branch (CBZ, CBNZ, B, BR) arrives from EX. Sits in IF and drives the instruction memory.

---
 rtl/pc_pkg.sv | 33 +++
 rtl/pc_if.sv | 30 +++
 rtl/pc_target_gen.sv | 32 +++
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and encodings for the fetch-address sequencer.
// Branch kinds match the EX-stage encoding; the helper decides whether a resolved branch redirects.
package pc_pkg;

    localparam logic [1:0] BR_CBZ  = 2'd0;
    localparam logic [1:0] BR_CBNZ = 2'd1;
    localparam logic [1:0] BR_B    = 2'd2;
    localparam logic [1:0] BR_BR   = 2'd3;

    typedef enum logic [1:0] {
        CBZ  = BR_CBZ,
        CBNZ = BR_CBNZ,
        B    = BR_B,
        BR   = BR_BR
    } br_kind_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    function automatic logic is_taken(input br_kind_t kind, input logic alu_zero);
        logic taken;
        case (kind)
            CBZ:     taken = alu_zero;
            CBNZ:    taken = !alu_zero;
            default: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_if.sv
// Bus between the IF-stage sequencer and its surroundings (hazard unit, EX branch resolution, I-mem).
// The slave modport is the sequencer's view; master is the driving environment.
interface pc_if #(
    parameter int ADDR_W   = 64,
    parameter int OFFSET_W = 19
);
    logic                Stall_i;
    logic                Halt_i;
    logic                BrValid_i;
    logic [1:0]          BrKind_i;
    logic                ALUZero_i;
    logic [ADDR_W-1:0]   BrPC_i;
    logic [OFFSET_W-1:0] Offset_i;
    logic [ADDR_W-1:0]   RegTarget_i;
    logic [ADDR_W-1:0]   PC_o;
    logic                FetchValid_o;
    logic                Flush_o;
    logic                Halted_o;
    logic                Fault_o;

    modport slave (
        input  Stall_i, Halt_i, BrValid_i, BrKind_i, ALUZero_i, BrPC_i, Offset_i, RegTarget_i,
        output PC_o, FetchValid_o, Flush_o, Halted_o, Fault_o
    );

    modport master (
        output Stall_i, Halt_i, BrValid_i, BrKind_i, ALUZero_i, BrPC_i, Offset_i, RegTarget_i,
        input  PC_o, FetchValid_o, Flush_o, Halted_o, Fault_o
    );
endinterface

// File: rtl/pc_target_gen.sv
// Combinational branch resolution: taken decision and raw redirect target
// (PC-relative for B/CBZ/CBNZ, register for BR). Alignment is handled by the caller.
module pc_target_gen
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int OFFSET_W    = 19,
    parameter int INSTR_BYTES = 4
) (
    input  logic [1:0]          br_kind,
    input  logic                alu_zero,
    input  logic [ADDR_W-1:0]   br_pc,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [ADDR_W-1:0]   reg_target,
    output logic                taken,
    output logic [ADDR_W-1:0]   target
);
    localparam int SHIFT = $clog2(INSTR_BYTES);

    br_kind_t          kind;
    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] rel_target;

    assign kind       = br_kind_t'(br_kind);
    assign offset_ext = {{(ADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    // Word offset scaled to bytes; the add wraps modulo 2^ADDR_W by construction.
    assign rel_target = br_pc + (offset_ext << SHIFT);

    assign taken  = is_taken(kind, alu_zero);
    assign target = (kind == BR) ? reg_target : rel_target;

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage fetch PC sequencer: BOOT/RUN/HALT FSM, registered PC with branch redirect, stall and flush.
// Optional PC_ALIGN_CHECK_EN: misaligned targets fault and halt instead of being silently aligned.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 64,
    parameter int                OFFSET_W    = 19,
    parameter int                INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input logic Clk,
    input logic Rst_n,
    pc_if.slave bus
);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSTR_BYTES);

    pc_state_t         state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              fetch_valid_reg;
    logic              flush_reg;
    logic              halted_reg;
    logic              br_taken;
    logic              redirect;
    logic [ADDR_W-1:0] raw_target;

    pc_target_gen #(
        .ADDR_W      (ADDR_W),
        .OFFSET_W    (OFFSET_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_target_gen (
        .br_kind    (bus.BrKind_i),
        .alu_zero   (bus.ALUZero_i),
        .br_pc      (bus.BrPC_i),
        .offset     (bus.Offset_i),
        .reg_target (bus.RegTarget_i),
        .taken      (br_taken),
        .target     (raw_target)
    );

    assign redirect = bus.BrValid_i && br_taken;

`ifdef PC_ALIGN_CHECK_EN
    logic fault_reg;
    logic bad_target;
    assign bad_target = |(raw_target & LOW_MASK);
    assign bus.Fault_o = fault_reg;
`else
    logic [ADDR_W-1:0] target_fixed;
    assign target_fixed = raw_target & ~LOW_MASK;
    assign bus.Fault_o  = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_VEC;
            fetch_valid_reg <= 1'b0;
            flush_reg       <= 1'b0;
            halted_reg      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fault_reg       <= 1'b0;
`endif
        end else begin
            flush_reg <= 1'b0;
            case (state_reg)
                BOOT: begin
                    state_reg       <= RUN;
                    fetch_valid_reg <= 1'b1;
                end
                RUN: begin
                    if (redirect) begin
                        // A taken branch beats a stall: the stalled wrong-path fetch is killed.
                        flush_reg <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                        if (bad_target) begin
                            fault_reg       <= 1'b1;
                            state_reg       <= HALT;
                            fetch_valid_reg <= 1'b0;
                            halted_reg      <= 1'b1;
                        end else begin
                            pc_reg <= raw_target;
                        end
`else
                        pc_reg <= target_fixed;
`endif
                    end else if (!bus.Stall_i) begin
                        pc_reg <= pc_reg + STEP;
                    end
                    if (bus.Halt_i) begin
                        state_reg       <= HALT;
                        fetch_valid_reg <= 1'b0;
                        halted_reg      <= 1'b1;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg       <= HALT;
                    fetch_valid_reg <= 1'b0;
                    halted_reg      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.PC_o         = pc_reg;
    assign bus.FetchValid_o = fetch_valid_reg;
    assign bus.Flush_o      = flush_reg;
    assign bus.Halted_o     = halted_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then randomized traffic, each cycle compared
// against a behavioural model of the fetch PC written from the branch/stall/halt rules.
module tb_pc_sequencer;
    localparam int ADDR_W   = 64;
    localparam int OFFSET_W = 19;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Model: mode 0 = boot, 1 = running, 2 = halted
    int          m_mode;
    logic [63:0] m_pc;
    logic        m_flush;
    logic        m_fault;

    pc_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) bus ();

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .OFFSET_W    (OFFSET_W),
        .INSTR_BYTES (4),
        .RESET_VEC   (64'h0)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},     bus.PC_o,                 m_pc);
        chk({tag, ".fvalid"}, 64'(bus.FetchValid_o),    64'(m_mode == 1));
        chk({tag, ".flush"},  64'(bus.Flush_o),         64'(m_flush));
        chk({tag, ".halted"}, 64'(bus.Halted_o),        64'(m_mode == 2));
        chk({tag, ".fault"},  64'(bus.Fault_o),         64'(m_fault));
        $display("t=%0t %s pc=%h fv=%0b flush=%0b halted=%0b fault=%0b", $time, tag,
                 bus.PC_o, bus.FetchValid_o, bus.Flush_o, bus.Halted_o, bus.Fault_o);
    endtask

    task automatic clear_inputs();
        bus.Stall_i     = 1'b0;
        bus.Halt_i      = 1'b0;
        bus.BrValid_i   = 1'b0;
        bus.BrKind_i    = 2'd0;
        bus.ALUZero_i   = 1'b0;
        bus.BrPC_i      = '0;
        bus.Offset_i    = '0;
        bus.RegTarget_i = '0;
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 64'h0;
        m_flush = 1'b0;
        m_fault = 1'b0;
    endtask

    // Next-state of the model from the inputs presented during the current cycle.
    task automatic model_step();
        bit          taken;
        longint      off_v;
        logic [63:0] tgt;
        m_flush = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            case (bus.BrKind_i)
                2'd0:    taken = bus.ALUZero_i;
                2'd1:    taken = !bus.ALUZero_i;
                default: taken = 1'b1;
            endcase
            taken = taken && bus.BrValid_i;
            if (taken) begin
                off_v = longint'(bus.Offset_i);
                if (off_v >= (64'sd1 <<< (OFFSET_W - 1))) off_v = off_v - (64'sd1 <<< OFFSET_W);
                if (bus.BrKind_i == 2'd3) tgt = bus.RegTarget_i;
                else                      tgt = bus.BrPC_i + 64'(off_v * 4);
                m_flush = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                if (tgt % 4 != 0) begin
                    m_fault = 1'b1;
                    m_mode  = 2;
                end else begin
                    m_pc = tgt;
                end
`else
                m_pc = tgt - (tgt % 4);
`endif
            end else if (!bus.Stall_i) begin
                m_pc = m_pc + 64'd4;
            end
            if (bus.Halt_i) m_mode = 2;
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic reset_dut();
        Rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check_all("reset");
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        check_all("release");
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset_hold");
        Rst_n = 1'b1;
        check_all("boot");
        cycle("run0");
        chk("seq0", bus.PC_o, 64'h0);
        cycle("run1");
        chk("seq4", bus.PC_o, 64'h4);
        cycle("run2");
        chk("seq8", bus.PC_o, 64'h8);

        // CBZ taken backwards
        bus.BrValid_i = 1'b1; bus.BrKind_i = 2'd0; bus.ALUZero_i = 1'b1;
        bus.BrPC_i = 64'h10; bus.Offset_i = 19'h7FFFE;
        cycle("cbz_taken");
        chk("cbz_target", bus.PC_o, 64'h8);
        chk("cbz_flush", 64'(bus.Flush_o), 64'd1);
        clear_inputs();
        cycle("after_cbz");
        chk("flush_one_cycle", 64'(bus.Flush_o), 64'd0);

        // CBZ not taken: sequential from current PC
        bus.BrValid_i = 1'b1; bus.BrKind_i = 2'd0; bus.ALUZero_i = 1'b0;
        bus.BrPC_i = 64'h10; bus.Offset_i = 19'h7FFFE;
        cycle("cbz_not_taken");
        chk("cbz_nt_pc", bus.PC_o, 64'h10);

        // CBNZ with simultaneous stall: branch wins
        bus.BrValid_i = 1'b1; bus.BrKind_i = 2'd1; bus.ALUZero_i = 1'b0;
        bus.BrPC_i = 64'h20; bus.Offset_i = 19'd3; bus.Stall_i = 1'b1;
        cycle("cbnz_stall");
        chk("cbnz_pc", bus.PC_o, 64'h2C);
        clear_inputs();
        bus.Stall_i = 1'b1;
        cycle("stall_hold");
        chk("stall_pc", bus.PC_o, 64'h2C);
        clear_inputs();
        cycle("stall_release");

        // BR to misaligned register target
        bus.BrValid_i = 1'b1; bus.BrKind_i = 2'd3; bus.RegTarget_i = 64'h1002;
        cycle("br_misaligned");
`ifdef PC_ALIGN_CHECK_EN
        chk("br_fault", 64'(bus.Fault_o), 64'd1);
        chk("br_pc_held", bus.PC_o, 64'h30);
`else
        chk("br_aligned", bus.PC_o, 64'h1000);
`endif
        clear_inputs();
        cycle("after_br");

        // Halt together with a taken branch: redirect first, then freeze
        reset_dut();
        cycle("boot2");
        bus.BrValid_i = 1'b1; bus.BrKind_i = 2'd2; bus.BrPC_i = 64'h40;
        bus.Offset_i = 19'd4; bus.Halt_i = 1'b1;
        cycle("halt_with_b");
        chk("halt_b_pc", bus.PC_o, 64'h50);
        bus.Halt_i = 1'b0; bus.Offset_i = 19'd100;
        cycle("halted_branch_ignored");

        // Wrap-around at the top of the address space, then halt
        reset_dut();
        cycle("boot3");
        bus.BrValid_i = 1'b1; bus.BrKind_i = 2'd3; bus.RegTarget_i = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle("br_top");
        clear_inputs();
        cycle("wrap");
        chk("wrap_zero", bus.PC_o, 64'h0);
        bus.Halt_i = 1'b1;
        cycle("halt_seq");
        bus.Halt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.BrValid_i = 1'b1; bus.BrKind_i = 2'($urandom_range(0, 3));
            bus.ALUZero_i = 1'($urandom); bus.Stall_i = 1'($urandom);
            bus.BrPC_i = 64'h100; bus.Offset_i = 19'($urandom);
            bus.RegTarget_i = {$urandom, $urandom};
            cycle("halt_frozen");
        end

        // Randomized traffic
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
                reset_dut();
            end else begin
                bus.Stall_i     = ($urandom_range(0, 3) == 0);
                bus.Halt_i      = ($urandom_range(0, 63) == 0);
                bus.BrValid_i   = ($urandom_range(0, 2) == 0);
                bus.BrKind_i    = 2'($urandom_range(0, 3));
                bus.ALUZero_i   = 1'($urandom);
                bus.BrPC_i      = {32'h0, $urandom} & ~64'h3;
                bus.Offset_i    = 19'($urandom);
                bus.RegTarget_i = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) bus.RegTarget_i[1:0] = 2'b00;
                cycle("rand");
            end
        end

        // Asynchronous reset in the middle of a redirect cycle
        reset_dut();
        cycle("boot4");
        bus.BrValid_i = 1'b1; bus.BrKind_i = 2'd2; bus.BrPC_i = 64'h200; bus.Offset_i = 19'd8;
        cycle("redirect_before_reset");
        chk("redirect_flush", 64'(bus.Flush_o), 64'd1);
        #2;
        Rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check_all("async_reset");
        chk("async_pc", bus.PC_o, 64'h0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        check_all("release2");
        cycle("post_reset0");
        cycle("post_reset1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
